// File: rtl/id_pkg.sv
// Shared decode constants for the ID stage: opcodes, ALU op encoding,
// IF/ID field positions and the ID/EX control bundle.
package id_pkg;

  localparam int REG_AW = 5;

  localparam int IF_ID_PC_HI    = 63;
  localparam int IF_ID_PC_LO    = 32;
  localparam int IF_ID_INSTR_HI = 31;
  localparam int IF_ID_INSTR_LO = 0;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic    valid;
    alu_op_e alu_op;
    logic    alu_a_pc;
    logic    alu_b_imm;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    mem_to_reg;
    logic    branch;
    logic    jump;
  } ctrl_t;

  // alt selects SUB over ADD and SRA over SRL; caller decides when it applies
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    op = ALU_ADD;
    case (funct3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// Architectural register file: 2 combinational read ports, 1 write port,
// x0 hardwired to zero, same-cycle bypass of the writeback value.
module reg_file
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [XLEN-1:0]   rdata1_o,
  output logic [XLEN-1:0]   rdata2_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i
);

  logic [XLEN-1:0] rf_q [1:NREG-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 1; i < NREG; i++) rf_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = '0;
    rdata2_o = '0;
    if (raddr1_i != '0) rdata1_o = (we_i && (waddr_i == raddr1_i)) ? wdata_i : rf_q[raddr1_i];
    if (raddr2_i != '0) rdata2_o = (we_i && (waddr_i == raddr2_i)) ? wdata_i : rf_q[raddr2_i];
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: unpacks IF/ID, decodes, reads operands, detects
// load-use hazards and registers the ID/EX bundle.
module id_stage
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*XLEN-1:0]   if_id,
  input  logic                wb_we,
  input  logic [REG_AW-1:0]   wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                ex_flush,
  output logic                stall,
  output logic                ex_valid,
  output logic [XLEN-1:0]     ex_pc,
  output logic [XLEN-1:0]     ex_rs1_data,
  output logic [XLEN-1:0]     ex_rs2_data,
  output logic [XLEN-1:0]     ex_imm,
  output logic [REG_AW-1:0]   ex_rs1,
  output logic [REG_AW-1:0]   ex_rs2,
  output logic [REG_AW-1:0]   ex_rd,
  output logic [2:0]          ex_funct3,
  output logic [3:0]          ex_alu_op,
  output logic                ex_alu_a_pc,
  output logic                ex_alu_b_imm,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_reg_write,
  output logic                ex_mem_to_reg,
  output logic                ex_branch,
  output logic                ex_jump
);

  logic [XLEN-1:0]   pc, instr;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]   rs1_val, rs2_val;
  logic [XLEN-1:0]   imm_i, imm_s, imm_b, imm_u, imm_j;
  ctrl_t             ctrl_dec;
  logic [XLEN-1:0]   imm_dec;
  logic              uses_rs1, uses_rs2;

  ctrl_t             ctrl_d, ctrl_q;
  logic [XLEN-1:0]   pc_d, pc_q, rs1_data_d, rs1_data_q, rs2_data_d, rs2_data_q, imm_d, imm_q;
  logic [REG_AW-1:0] rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
  logic [2:0]        funct3_d, funct3_q;

  assign pc     = if_id[IF_ID_PC_HI:IF_ID_PC_LO];
  assign instr  = if_id[IF_ID_INSTR_HI:IF_ID_INSTR_LO];
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  reg_file #(.XLEN(XLEN), .NREG(NREG)) u_reg_file (
    .clk_i    (clk),
    .rst_ni   (rst),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rs1_val),
    .rdata2_o (rs2_val),
    .we_i     (wb_we),
    .waddr_i  (wb_rd),
    .wdata_i  (wb_data)
  );

  always_comb begin
    ctrl_dec = '0;
    imm_dec  = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OPC_R: begin
        ctrl_dec.valid     = 1'b1;
        ctrl_dec.alu_op    = alu_from_funct3(funct3, instr[30]);
        ctrl_dec.reg_write = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_IALU: begin
        ctrl_dec.valid     = 1'b1;
        ctrl_dec.alu_op    = alu_from_funct3(funct3, instr[30] & (funct3 == 3'b101));
        ctrl_dec.alu_b_imm = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        imm_dec  = imm_i;
        uses_rs1 = 1'b1;
      end
      OPC_LOAD: begin
        ctrl_dec.valid      = 1'b1;
        ctrl_dec.alu_b_imm  = 1'b1;
        ctrl_dec.mem_read   = 1'b1;
        ctrl_dec.reg_write  = 1'b1;
        ctrl_dec.mem_to_reg = 1'b1;
        imm_dec  = imm_i;
        uses_rs1 = 1'b1;
      end
      OPC_STORE: begin
        ctrl_dec.valid     = 1'b1;
        ctrl_dec.alu_b_imm = 1'b1;
        ctrl_dec.mem_write = 1'b1;
        imm_dec  = imm_s;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl_dec.valid  = 1'b1;
        ctrl_dec.alu_op = ALU_SUB;
        ctrl_dec.branch = 1'b1;
        imm_dec  = imm_b;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_JAL: begin
        ctrl_dec.valid     = 1'b1;
        ctrl_dec.alu_a_pc  = 1'b1;
        ctrl_dec.alu_b_imm = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.jump      = 1'b1;
        imm_dec = imm_j;
      end
      OPC_JALR: begin
        ctrl_dec.valid     = 1'b1;
        ctrl_dec.alu_b_imm = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.jump      = 1'b1;
        imm_dec  = imm_i;
        uses_rs1 = 1'b1;
      end
      OPC_LUI: begin
        ctrl_dec.valid     = 1'b1;
        ctrl_dec.alu_op    = ALU_PASSB;
        ctrl_dec.alu_b_imm = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        imm_dec = imm_u;
      end
      OPC_AUIPC: begin
        ctrl_dec.valid     = 1'b1;
        ctrl_dec.alu_a_pc  = 1'b1;
        ctrl_dec.alu_b_imm = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        imm_dec = imm_u;
      end
      default: ;
    endcase
    if (rd == '0) ctrl_dec.reg_write = 1'b0;
  end

  // Flush suppresses stall so IF is free to redirect in the same cycle
  assign stall = ~ex_flush & ctrl_q.valid & ctrl_q.mem_read & (rd_q != '0) &
                 ((uses_rs1 & (rd_q == rs1)) | (uses_rs2 & (rd_q == rs2)));

  always_comb begin
    ctrl_d     = ctrl_dec;
    pc_d       = pc;
    rs1_data_d = rs1_val;
    rs2_data_d = rs2_val;
    imm_d      = imm_dec;
    rs1_d      = rs1;
    rs2_d      = rs2;
    rd_d       = rd;
    funct3_d   = funct3;
    if (ex_flush || stall || !ctrl_dec.valid) begin
      ctrl_d     = '0;
      pc_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
      funct3_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q     <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      funct3_q   <= funct3_d;
    end
  end

  assign ex_valid      = ctrl_q.valid;
  assign ex_pc         = pc_q;
  assign ex_rs1_data   = rs1_data_q;
  assign ex_rs2_data   = rs2_data_q;
  assign ex_imm        = imm_q;
  assign ex_rs1        = rs1_q;
  assign ex_rs2        = rs2_q;
  assign ex_rd         = rd_q;
  assign ex_funct3     = funct3_q;
  assign ex_alu_op     = ctrl_q.alu_op;
  assign ex_alu_a_pc   = ctrl_q.alu_a_pc;
  assign ex_alu_b_imm  = ctrl_q.alu_b_imm;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_branch     = ctrl_q.branch;
  assign ex_jump       = ctrl_q.jump;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed cases plus random instruction streams checked
// against an instruction-level reference model with its own register array.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] if_id;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_flush;
  logic        stall, ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_a_pc, ex_alu_b_imm, ex_mem_read, ex_mem_write;
  logic        ex_reg_write, ex_mem_to_reg, ex_branch, ex_jump;

  id_stage dut (
    .clk(clk), .rst(rst), .if_id(if_id), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .ex_flush(ex_flush), .stall(stall), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_alu_op(ex_alu_op), .ex_alu_a_pc(ex_alu_a_pc),
    .ex_alu_b_imm(ex_alu_b_imm), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_jump(ex_jump)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [3:0]  op;
    logic        apc, bimm, mr, mw, rw, m2r, br, j, u1, u2, has_imm;
  } exp_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_rf [32];
  exp_t        cur;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rf_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_we && wb_rd == a) return wb_data;
    return m_rf[a];
  endfunction

  // Instruction-level view: what ID/EX should hold for word w if it is accepted
  function automatic exp_t predict(input logic [63:0] w);
    exp_t        e;
    logic [31:0] ins, sx, imm_i;
    logic [3:0]  base [8];
    logic        alt;
    base  = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    e     = '0;
    ins   = w[31:0];
    sx    = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    imm_i = (sx << 12) | 32'(ins[31:20]);
    e.pc  = w[63:32];
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    e.f3  = ins[14:12];
    case (ins[6:0])
      7'h33: begin
        e.valid = 1; e.rw = 1; e.u1 = 1; e.u2 = 1;
        alt  = ins[30] && (e.f3 == 3'd0 || e.f3 == 3'd5);
        e.op = base[e.f3] + 4'(alt);
      end
      7'h13: begin
        e.valid = 1; e.rw = 1; e.u1 = 1; e.bimm = 1; e.has_imm = 1;
        alt   = ins[30] && (e.f3 == 3'd5);
        e.op  = base[e.f3] + 4'(alt);
        e.imm = imm_i;
      end
      7'h03: begin
        e.valid = 1; e.rw = 1; e.u1 = 1; e.bimm = 1; e.mr = 1; e.m2r = 1; e.has_imm = 1;
        e.imm = imm_i;
      end
      7'h23: begin
        e.valid = 1; e.u1 = 1; e.u2 = 1; e.bimm = 1; e.mw = 1; e.has_imm = 1;
        e.imm = (sx << 12) | (32'(ins[31:25]) << 5) | 32'(ins[11:7]);
      end
      7'h63: begin
        e.valid = 1; e.u1 = 1; e.u2 = 1; e.br = 1; e.op = 4'd1; e.has_imm = 1;
        e.imm = (sx << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      end
      7'h6F: begin
        e.valid = 1; e.rw = 1; e.apc = 1; e.bimm = 1; e.j = 1; e.has_imm = 1;
        e.imm = (sx << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      end
      7'h67: begin
        e.valid = 1; e.rw = 1; e.u1 = 1; e.bimm = 1; e.j = 1; e.has_imm = 1;
        e.imm = imm_i;
      end
      7'h37: begin
        e.valid = 1; e.rw = 1; e.bimm = 1; e.op = 4'd10; e.has_imm = 1;
        e.imm = ins & 32'hFFFF_F000;
      end
      7'h17: begin
        e.valid = 1; e.rw = 1; e.apc = 1; e.bimm = 1; e.has_imm = 1;
        e.imm = ins & 32'hFFFF_F000;
      end
      default: ;
    endcase
    if (e.rd == 5'd0) e.rw = 0;
    e.rs1d = rf_read(e.rs1);
    e.rs2d = rf_read(e.rs2);
    if (!e.valid) e = '0;
    return e;
  endfunction

  task automatic check_ex(input string tag);
    chk({tag, ".valid"}, 32'(ex_valid), 32'(cur.valid));
    chk({tag, ".ctrl"},
        {ex_alu_op, ex_alu_a_pc, ex_alu_b_imm, ex_mem_read, ex_mem_write,
         ex_reg_write, ex_mem_to_reg, ex_branch, ex_jump},
        {cur.op, cur.apc, cur.bimm, cur.mr, cur.mw, cur.rw, cur.m2r, cur.br, cur.j});
    if (cur.valid) begin
      chk({tag, ".pc"}, ex_pc, cur.pc);
      chk({tag, ".regs"}, {ex_funct3, ex_rs1, ex_rs2, ex_rd}, {cur.f3, cur.rs1, cur.rs2, cur.rd});
      if (cur.u1) chk({tag, ".rs1_data"}, ex_rs1_data, cur.rs1d);
      if (cur.u2) chk({tag, ".rs2_data"}, ex_rs2_data, cur.rs2d);
      if (cur.has_imm) chk({tag, ".imm"}, ex_imm, cur.imm);
    end
  endtask

  task automatic step(input logic [63:0] w, input logic we, input logic [4:0] wrd,
                      input logic [31:0] wd, input logic fl, input string tag,
                      output logic st);
    exp_t p;
    logic st_exp;
    if_id = w; wb_we = we; wb_rd = wrd; wb_data = wd; ex_flush = fl;
    #1;
    p = predict(w);
    st_exp = !fl && cur.valid && cur.mr && (cur.rd != 5'd0) &&
             ((p.u1 && cur.rd == p.rs1) || (p.u2 && cur.rd == p.rs2));
    st = stall;
    chk({tag, ".stall"}, 32'(stall), 32'(st_exp));
    if (we && wrd != 5'd0) m_rf[wrd] = wd;
    @(posedge clk);
    #1;
    cur = (fl || st_exp) ? '0 : p;
    check_ex(tag);
  endtask

  logic [63:0] w;
  logic [31:0] ins;
  logic        st, hold, fl, we;
  logic [4:0]  wrd;
  logic [6:0]  opcs [10];

  initial begin
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};
    rst = 1'b0; if_id = '0; wb_we = 0; wb_rd = '0; wb_data = '0; ex_flush = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    cur = '0;
    #12;
    check_ex("rst");
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.data", ex_pc | ex_rs1_data | ex_rs2_data | ex_imm, 32'd0);
    chk("rst.fields", {ex_rs1, ex_rs2, ex_rd, ex_funct3}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    step(64'd0, 0, 5'd0, 32'd0, 0, "zero", st);
    chk("zero.pc", ex_pc, 32'd0);

    step({32'h100, 32'h002081B3}, 1, 5'd1, 32'd5, 0, "byp", st);
    chk("byp.rs1_data", ex_rs1_data, 32'd5);
    chk("byp.rd", 32'(ex_rd), 32'd3);
    chk("byp.op", 32'(ex_alu_op), 32'd0);
    chk("byp.rw", 32'(ex_reg_write), 32'd1);

    step(64'd0, 1, 5'd2, 32'h1234, 0, "wr_x2", st);
    step({32'h180, 32'h002081B3}, 0, 5'd0, 32'd0, 0, "rd_x2", st);
    chk("rd_x2.rs2_data", ex_rs2_data, 32'h1234);

    step({32'h200, 32'h0000A283}, 0, 5'd0, 32'd0, 0, "lu_ld", st);
    step({32'h204, 32'h00528333}, 0, 5'd0, 32'd0, 0, "lu_add", st);
    chk("lu.stall", 32'(st), 32'd1);
    chk("lu.bubble", 32'(ex_valid), 32'd0);
    step({32'h204, 32'h00528333}, 0, 5'd0, 32'd0, 0, "lu_hold", st);
    chk("lu_hold.stall", 32'(st), 32'd0);
    chk("lu_hold.valid", 32'(ex_valid), 32'd1);

    step({32'h300, 32'hFE208EE3}, 0, 5'd0, 32'd0, 0, "beq", st);
    chk("beq.imm", ex_imm, 32'hFFFF_FFFC);
    chk("beq.ctl", {ex_branch, ex_alu_op, ex_alu_b_imm, ex_funct3}, {1'b1, 4'd1, 1'b0, 3'd0});

    step({32'h200, 32'h0000A283}, 0, 5'd0, 32'd0, 0, "fl_ld", st);
    step({32'h204, 32'h00528333}, 0, 5'd0, 32'd0, 1, "fl_add", st);
    chk("fl.stall", 32'(st), 32'd0);
    chk("fl.valid", 32'(ex_valid), 32'd0);

    step({32'h400, 32'h00202423}, 1, 5'd0, 32'hDEAD, 0, "sw0", st);
    chk("sw0.rs1_data", ex_rs1_data, 32'd0);
    chk("sw0.imm", ex_imm, 32'd8);
    chk("sw0.mw_rw", {ex_mem_write, ex_reg_write}, 32'b10);
    step({32'h404, 32'h0020A423}, 1, 5'd0, 32'hDEAD, 0, "sw1", st);

    // Asynchronous reset mid-cycle with a valid instruction in ID/EX
    #3;
    rst = 1'b0;
    #1;
    chk("arst.valid", 32'(ex_valid), 32'd0);
    chk("arst.mw", 32'(ex_mem_write), 32'd0);
    chk("arst.pc", ex_pc, 32'd0);
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    cur = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    step({32'h500, 32'h002081B3}, 0, 5'd0, 32'd0, 0, "arst_rd", st);
    chk("arst_rd.x1", ex_rs1_data, 32'd0);

    hold = 0;
    for (int k = 0; k < 400; k++) begin
      if (!hold) begin
        ins        = $urandom;
        ins[6:0]   = opcs[$urandom_range(0, 9)];
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        w = {$urandom, ins};
      end
      fl  = ($urandom_range(0, 9) == 0);
      we  = 1'($urandom_range(0, 1));
      wrd = 5'($urandom_range(0, 7));
      step(w, we, wrd, $urandom, fl, "rnd", st);
      hold = st;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
